// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-dump reader.
//   state_t       : FSM state encoding (2-bit), also exported on the debug state port
//   DEF_*         : default sizes shared with the register file and debug display path
package reg_dump_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam int DEF_NUM_REGS  = 32;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_FIRST_REG = 0;

endpackage

// File: rtl/reg_dump_reader.sv
// Debug-side register dump reader.
// On a start pulse it walks the register file's debug read address over
// FIRST_REG..NUM_REGS-1 and streams (index, data) pairs out on a valid/ready port.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a dump (only honoured in IDLE)
//   abort      : cancel a dump in progress (wins over start and handshakes)
//   dbg_addr   : debug read address to the register file (combinational from state)
//   dbg_data   : debug read data from the register file (combinational)
//   out_valid, out_ready, out_idx, out_data, out_last : output word stream
//   busy       : high while loading or sending
//   done       : one-cycle pulse after the last word is accepted
//   state      : current FSM state, for observation only
//
// Handshake: a word transfers on any posedge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_idx/out_data/out_last are
// held unchanged. out_valid never drops without a transfer except on abort/rst.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FIRST_REG = DEF_FIRST_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_t state_q, state_d;
  logic   load_word;   // capture the first word (FIRST_REG)
  logic   advance;     // handshake on a non-last word: capture the next one
  logic   finish;      // handshake on the last word

  // Next-state and datapath controls.
  always_comb begin
    state_d   = state_q;
    dbg_addr  = FIRST_IDX;
    load_word = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_word = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        // Prefetch the next index so its data is ready at the handshake edge.
        dbg_addr = (out_idx == LAST_IDX) ? FIRST_IDX : out_idx + ADDR_W'(1);
        if (out_ready) begin
          if (out_idx == LAST_IDX) begin
            finish  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // abort overrides everything, including start in IDLE and a handshake.
    if (abort) begin
      state_d   = ST_IDLE;
      load_word = 1'b0;
      advance   = 1'b0;
      finish    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (abort) begin
        // Index and data keep their last values.
        out_valid <= 1'b0;
      end else if (load_word) begin
        out_valid <= 1'b1;
        out_idx   <= FIRST_IDX;
        out_data  <= dbg_data;
      end else if (advance) begin
        out_idx  <= out_idx + ADDR_W'(1);
        out_data <= dbg_data;
      end else if (finish) begin
        out_valid <= 1'b0;
        done      <= 1'b1;
      end
    end
  end

  assign out_last = out_valid && (out_idx == LAST_IDX);
  assign busy     = (state_q != ST_IDLE);
  assign state    = state_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int FR_B = 29;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic start_b = 1'b0;

  logic [AW-1:0] dbg_addr, out_idx, dbg_addr_b, out_idx_b;
  logic [DW-1:0] dbg_data, out_data, dbg_data_b, out_data_b;
  logic out_valid, out_last, busy, done;
  logic out_valid_b, out_last_b, busy_b, done_b;
  logic [1:0] state, state_b;

  // Register file model: combinational read, index 0 reads as zero.
  logic [DW-1:0] regs [NR];
  assign dbg_data   = (dbg_addr == 0)   ? '0 : regs[dbg_addr];
  assign dbg_data_b = (dbg_addr_b == 0) ? '0 : regs[dbg_addr_b];

  reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .FIRST_REG(0)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .state(state)
  );

  reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .FIRST_REG(FR_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(1'b0),
    .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_idx(out_idx_b),
    .out_data(out_data_b), .out_last(out_last_b), .busy(busy_b), .done(done_b), .state(state_b)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ready driver ----------------
  // mode 0: always ready, 1: toggle each cycle, 2: random. stop_idx forces a stall.
  int ready_mode = 0;
  int stop_idx = -1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (stop_idx >= 0 && out_valid && out_idx == AW'(stop_idx)) out_ready = 1'b0;
  end

  // ---------------- scoreboard ----------------
  logic [AW+DW:0] exp_q[$];
  logic [AW+DW:0] exp_qb[$];

  // Expected stream of a dump: one word per index, data as the register file
  // holds it (with an optional planned mid-dump overwrite of one register).
  function automatic void push_words(int first, int upto, int ov_idx, logic [DW-1:0] ov_val);
    for (int i = first; i <= upto; i++) begin
      logic [DW-1:0] d;
      d = (i == 0) ? '0 : ((i == ov_idx) ? ov_val : regs[i]);
      exp_q.push_back({(i == NR - 1), AW'(i), d});
    end
  endfunction

  // ---------------- monitor A ----------------
  logic pend_done = 1'b0, prev_stall = 1'b0, prev_abort = 1'b0;
  logic [AW-1:0] prev_idx;
  logic [DW-1:0] prev_data;
  int done_cnt = 0;
  int t_first = 0, t_last = 0;

  always @(negedge clk) begin
    if (rst) begin
      pend_done  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (pend_done || done) check("done_pulse", done, pend_done);
      if (done) begin
        done_cnt++;
        check("done_vs_valid", out_valid, 1'b0);
      end
      if (prev_stall && !prev_abort) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_word", {out_idx, out_data}, {prev_idx, prev_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word: got idx %0d data %0h, expected no word", out_idx, out_data);
        end else begin
          logic [AW+DW:0] e;
          e = exp_q.pop_front();
          check("word", {out_last, out_idx, out_data}, e);
        end
        if (out_idx == 0) t_first = cyc;
        if (out_last) t_last = cyc;
      end
      pend_done  = out_valid && out_ready && out_last && !abort;
      prev_stall = out_valid && !out_ready;
      prev_abort = abort;
      prev_idx   = out_idx;
      prev_data  = out_data;
    end
  end

  // ---------------- monitor B (FIRST_REG = 29) ----------------
  int done_cnt_b = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (done_b) done_cnt_b++;
      if (out_valid_b && out_ready) begin
        if (exp_qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_word: got idx %0d, expected no word", out_idx_b);
        end else begin
          logic [AW+DW:0] e;
          e = exp_qb.pop_front();
          check("b_word", {out_last_b, out_idx_b, out_data_b}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    if (k == budget) begin
      total++; bad++;
      $display("FAIL %s_timeout: still busy=%0b with %0d words pending", name, busy, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_regs();
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
  endtask

  // ---------------- main sequence ----------------
  int exp_done;

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = DW'(i * 'h11);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_idx", out_idx, 0);
    check("rst_data", out_data, 0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", dbg_addr, 0);
    check("rst_addr_b", dbg_addr_b, FR_B);
    exp_done = 0;

    // 1: full dump, always ready, regs[i] = i*0x11; latency and throughput.
    ready_mode = 0;
    push_words(0, NR - 1, -1, '0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("lat_valid_early", out_valid, 1'b0);
    check("lat_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1'b1);
    check("first_idx", out_idx, 0);
    wait_idle("dump1", 200);
    exp_done++;
    check("done_cnt1", done_cnt, exp_done);
    check("throughput", t_last - t_first, NR - 1);

    // 2: toggling ready, random register contents.
    rand_regs();
    ready_mode = 1;
    push_words(0, NR - 1, -1, '0);
    pulse_start();
    wait_idle("dump2", 400);
    exp_done++;
    check("done_cnt2", done_cnt, exp_done);

    // 3: overwrite regs[5] just before it loads, then again after it is sent.
    rand_regs();
    ready_mode = 2;
    push_words(0, NR - 1, 5, 32'hDEADBEEF);
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (out_valid && out_idx == 4) break;
        end
        regs[5] = 32'hDEADBEEF;
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (out_valid && out_idx >= 6) break;
        end
        regs[5] = 32'h12345678;
      end
      begin
        pulse_start();
        wait_idle("dump3", 400);
      end
    join
    exp_done++;
    check("done_cnt3", done_cnt, exp_done);

    // 4: abort while stalled on idx 10, then a fresh dump from idx 0.
    rand_regs();
    ready_mode = 0;
    stop_idx = 10;
    push_words(0, 9, -1, '0);
    pulse_start();
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        @(negedge clk);
        if (out_valid && out_idx == 10) break;
      end
      if (k == 200) begin
        total++; bad++;
        $display("FAIL abort_reach_timeout: idx %0d valid %0b, expected idx 10", out_idx, out_valid);
      end
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    stop_idx = -1;
    @(negedge clk);
    check("abort_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_idx_kept", out_idx, 10);
    check("abort_data_kept", out_data, regs[10]);
    check("abort_q_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, exp_done);
    push_words(0, NR - 1, -1, '0);
    pulse_start();
    wait_idle("dump4", 200);
    exp_done++;
    check("done_cnt4", done_cnt, exp_done);

    // 5: start pulses during SEND are ignored; start && abort in IDLE stays IDLE.
    rand_regs();
    ready_mode = 2;
    push_words(0, NR - 1, -1, '0);
    pulse_start();
    repeat (3) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_idle("dump5", 400);
    repeat (5) @(negedge clk);
    exp_done++;
    check("done_cnt5", done_cnt, exp_done);
    @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
    @(negedge clk);
    check("start_abort_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("start_abort_valid", out_valid, 1'b0);

    // 6: FIRST_REG = 29 instance dumps exactly idx 29..31.
    rand_regs();
    ready_mode = 0;
    for (int i = FR_B; i < NR; i++) exp_qb.push_back({(i == NR - 1), AW'(i), regs[i]});
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    repeat (10) @(negedge clk);
    check("b_q_empty", exp_qb.size(), 0);
    check("b_done_cnt", done_cnt_b, 1);
    check("b_busy", busy_b, 1'b0);

    // 7: reset in the middle of a dump.
    ready_mode = 1;
    push_words(0, NR - 1, -1, '0);
    pulse_start();
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_idx", out_idx, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", done_cnt, exp_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
